// File: rtl/mem_pkg.sv
// ============================================================================
// mem_pkg : shared types for the M-stage data-memory request path
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_pkg;

    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADDR  = 2'd1,
        DATA  = 2'd2,
        DRAIN = 2'd3
    } dreq_state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef struct packed {
        logic                      wr;
        logic [1:0]                size;
        logic [MEM_ADDR_W-1:0]     addr;
        logic [MEM_DATA_W-1:0]     wdata;
        logic [MEM_DATA_W/8-1:0]   wstrb;
    } mem_req_t;

endpackage

`default_nettype wire

// File: rtl/dreq_slot_mux.sv
// ============================================================================
// dreq_slot_mux : picks the slot whose access drives the data port
// Rev 1.0
// ============================================================================
`default_nettype none

module dreq_slot_mux
    import mem_pkg::*;
(
    input  logic     use_cur_i,
    input  logic     cur_i,
    input  logic     need1_i,
    input  logic     need2_i,
    input  mem_req_t req1_i,
    input  mem_req_t req2_i,
    output logic     sel_o,
    output mem_req_t req_o
);

    // Slot 1 always wins a fresh arbitration; once issued, the latched slot holds.
    assign sel_o = use_cur_i ? cur_i : (~need1_i & need2_i);
    assign req_o = sel_o ? req2_i : req1_i;

endmodule

`default_nettype wire

// File: rtl/dmem_req_ctrl.sv
// ============================================================================
// dmem_req_ctrl : sequences dual-issue M-stage loads/stores onto one data port
// Rev 1.0
// ============================================================================
`default_nettype none

module dmem_req_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                m_valid1_i,
    input  logic                m_valid2_i,
    input  logic                kill1_i,
    input  logic                kill2_i,
    input  logic                wr1_i,
    input  logic                wr2_i,
    input  logic [1:0]          size1_i,
    input  logic [1:0]          size2_i,
    input  logic [ADDR_W-1:0]   addr1_i,
    input  logic [ADDR_W-1:0]   addr2_i,
    input  logic [DATA_W-1:0]   wdata1_i,
    input  logic [DATA_W-1:0]   wdata2_i,
    input  logic [DATA_W/8-1:0] wstrb1_i,
    input  logic [DATA_W/8-1:0] wstrb2_i,
    input  logic                pipe_adv_i,
    input  logic                flush_i,
    output logic                data_req_o,
    output logic                data_wr_o,
    output logic [1:0]          data_size_o,
    output logic [ADDR_W-1:0]   data_addr_o,
    output logic [DATA_W-1:0]   data_wdata_o,
    output logic [DATA_W/8-1:0] data_wstrb_o,
    input  logic                data_addr_ok_i,
    input  logic                data_data_ok_i,
    input  logic [DATA_W-1:0]   data_rdata_i,
    output logic [DATA_W-1:0]   rdata1_o,
    output logic [DATA_W-1:0]   rdata2_o,
    output logic                mem_stall_o
);

    dreq_state_t       state_q;
    logic              done1_q, done2_q;
    logic              cur_q;
    logic              flush_pend_q;
    logic [DATA_W-1:0] rdata1_q, rdata2_q;

    logic     w_need1, w_need2, w_issue, w_req_active, w_sel;
    mem_req_t w_req1, w_req2, w_req;

    // A slot-1 exception also cancels slot 2 so younger accesses never reach memory.
    assign w_need1 = m_valid1_i & ~kill1_i & ~done1_q;
    assign w_need2 = m_valid2_i & ~kill2_i & ~kill1_i & ~done2_q;
    assign w_issue = (state_q == IDLE) & (w_need1 | w_need2) & ~flush_i;

    assign w_req1 = '{wr: wr1_i, size: size1_i, addr: addr1_i, wdata: wdata1_i, wstrb: wstrb1_i};
    assign w_req2 = '{wr: wr2_i, size: size2_i, addr: addr2_i, wdata: wdata2_i, wstrb: wstrb2_i};

    dreq_slot_mux u_slot_mux (
        .use_cur_i (state_q != IDLE),
        .cur_i     (cur_q),
        .need1_i   (w_need1),
        .need2_i   (w_need2),
        .req1_i    (w_req1),
        .req2_i    (w_req2),
        .sel_o     (w_sel),
        .req_o     (w_req)
    );

    // Gating with rst makes the port go quiet the instant reset asserts.
    assign w_req_active = ~rst & (w_issue | (state_q == ADDR));

    assign data_req_o   = w_req_active;
    assign data_wr_o    = w_req_active & w_req.wr;
    assign data_size_o  = w_req_active ? w_req.size  : SZ_B;
    assign data_addr_o  = w_req_active ? w_req.addr  : '0;
    assign data_wdata_o = w_req_active ? w_req.wdata : '0;
    assign data_wstrb_o = w_req_active ? w_req.wstrb : '0;

    assign mem_stall_o = ~rst & ((state_q == ADDR) | (state_q == DATA) | w_need1 | w_need2 |
                                 ((state_q == DRAIN) & (m_valid1_i | m_valid2_i)));

    assign rdata1_o = rdata1_q;
    assign rdata2_o = rdata2_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            done1_q      <= 1'b0;
            done2_q      <= 1'b0;
            cur_q        <= 1'b0;
            flush_pend_q <= 1'b0;
            rdata1_q     <= '0;
            rdata2_q     <= '0;
        end else begin
            if (pipe_adv_i | flush_i) begin
                done1_q <= 1'b0;
                done2_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    flush_pend_q <= 1'b0;
                    if (w_issue) begin
                        cur_q   <= w_sel;
                        state_q <= data_addr_ok_i ? DATA : ADDR;
                    end
                end
                ADDR: begin
                    if (data_addr_ok_i) begin
                        flush_pend_q <= 1'b0;
                        state_q      <= (flush_pend_q | flush_i) ? DRAIN : DATA;
                    end else if (flush_i) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                DATA: begin
                    if (data_data_ok_i) begin
                        state_q <= IDLE;
                        if (!flush_i) begin
                            if (cur_q) begin
                                done2_q <= 1'b1;
                                if (!w_req.wr) rdata2_q <= data_rdata_i;
                            end else begin
                                done1_q <= 1'b1;
                                if (!w_req.wr) rdata1_q <= data_rdata_i;
                            end
                        end
                    end else if (flush_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (data_data_ok_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_dmem_req_ctrl.sv
// ============================================================================
// tb_dmem_req_ctrl : directed per-cycle vectors for dmem_req_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_req_ctrl;

    localparam logic [31:0] A1 = 32'h8000_1000;
    localparam logic [31:0] A2 = 32'h8000_1004;
    localparam logic [31:0] W1 = 32'hA5A5_A5A5;
    localparam logic [31:0] W2 = 32'h5A5A_5A5A;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] CF = 32'hCAFE_F00D;
    localparam logic [31:0] BD = 32'h0BAD_C0DE;
    localparam logic [31:0] GD = 32'h600D_F00D;

    logic        clk = 1'b0;
    logic        rst;
    logic        m_valid1, m_valid2, kill1, kill2, wr1, wr2;
    logic [1:0]  size1, size2;
    logic [31:0] addr1, addr2, wdata1, wdata2;
    logic [3:0]  wstrb1, wstrb2;
    logic        pipe_adv, flush;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata, rdata1, rdata2;
    logic        mem_stall;

    int checks = 0;
    int errors = 0;
    int row    = 0;

    always #5 clk = ~clk;

    dmem_req_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .m_valid1_i     (m_valid1),
        .m_valid2_i     (m_valid2),
        .kill1_i        (kill1),
        .kill2_i        (kill2),
        .wr1_i          (wr1),
        .wr2_i          (wr2),
        .size1_i        (size1),
        .size2_i        (size2),
        .addr1_i        (addr1),
        .addr2_i        (addr2),
        .wdata1_i       (wdata1),
        .wdata2_i       (wdata2),
        .wstrb1_i       (wstrb1),
        .wstrb2_i       (wstrb2),
        .pipe_adv_i     (pipe_adv),
        .flush_i        (flush),
        .data_req_o     (data_req),
        .data_wr_o      (data_wr),
        .data_size_o    (data_size),
        .data_addr_o    (data_addr),
        .data_wdata_o   (data_wdata),
        .data_wstrb_o   (data_wstrb),
        .data_addr_ok_i (data_addr_ok),
        .data_data_ok_i (data_data_ok),
        .data_rdata_i   (data_rdata),
        .rdata1_o       (rdata1),
        .rdata2_o       (rdata2),
        .mem_stall_o    (mem_stall)
    );

    // One record per clock cycle; eslot: 0 = no request, 1 = slot 1, 2 = slot 2.
    typedef struct {
        logic        mv1, mv2, k1, k2, wr1, wr2, pa, fl, aok, dok;
        logic [31:0] rd;
        logic [1:0]  eslot;
        logic        estall;
        logic [31:0] er1, er2;
    } vec_t;

    function automatic vec_t v(input logic mv1, mv2, k1, k2, w1, w2, pa, fl, aok, dok,
                               input logic [31:0] rd, input logic [1:0] eslot,
                               input logic estall, input logic [31:0] er1, er2);
        vec_t t;
        t.mv1 = mv1; t.mv2 = mv2; t.k1 = k1; t.k2 = k2; t.wr1 = w1; t.wr2 = w2;
        t.pa = pa; t.fl = fl; t.aok = aok; t.dok = dok; t.rd = rd;
        t.eslot = eslot; t.estall = estall; t.er1 = er1; t.er2 = er2;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, got, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        m_valid1 = t.mv1; m_valid2 = t.mv2; kill1 = t.k1; kill2 = t.k2;
        wr1 = t.wr1; wr2 = t.wr2; pipe_adv = t.pa; flush = t.fl;
        data_addr_ok = t.aok; data_data_ok = t.dok; data_rdata = t.rd;
    endtask

    task automatic compare(input vec_t t);
        logic        e_req;
        logic [31:0] e_addr, e_wd;
        logic        e_wr;
        e_req  = (t.eslot != 2'd0);
        e_addr = (t.eslot == 2'd1) ? A1 : (t.eslot == 2'd2) ? A2 : 32'h0;
        e_wd   = (t.eslot == 2'd1) ? W1 : (t.eslot == 2'd2) ? W2 : 32'h0;
        e_wr   = (t.eslot == 2'd1) ? t.wr1 : (t.eslot == 2'd2) ? t.wr2 : 1'b0;
        chk("data_req",   {31'b0, data_req},  {31'b0, e_req});
        chk("data_addr",  data_addr,          e_addr);
        chk("data_wdata", data_wdata,         e_wd);
        chk("data_wr",    {31'b0, data_wr},   {31'b0, e_wr});
        chk("data_wstrb", {28'b0, data_wstrb}, e_req ? 32'hF : 32'h0);
        chk("data_size",  {30'b0, data_size}, e_req ? 32'h2 : 32'h0);
        chk("mem_stall",  {31'b0, mem_stall}, {31'b0, t.estall});
        chk("rdata1",     rdata1,             t.er1);
        chk("rdata2",     rdata2,             t.er2);
    endtask

    // Entered 1 time unit after a rising edge; checks settle 2 units later.
    task automatic run(input vec_t t);
        drive(t);
        #2;
        compare(t);
        @(posedge clk);
        #1;
        row++;
    endtask

    vec_t tbl[$];
    vec_t z;

    initial begin
        z = v(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0);
        drive(z);
        size1 = 2'd2; size2 = 2'd2;
        addr1 = A1; addr2 = A2; wdata1 = W1; wdata2 = W2;
        wstrb1 = 4'hF; wstrb2 = 4'hF;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        tbl.push_back(z);
        // single LW from slot 1
        tbl.push_back(v(1,0,0,0,0,0,0,0,1,0,0,  1,1,0,0));
        tbl.push_back(v(1,0,0,0,0,0,0,0,0,1,DB, 0,1,0,0));
        tbl.push_back(v(1,0,0,0,0,0,1,0,0,0,0,  0,0,DB,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,  0,0,DB,0));
        // SW slot 1 then LW slot 2, back-to-back
        tbl.push_back(v(1,1,0,0,1,0,0,0,1,0,0,            1,1,DB,0));
        tbl.push_back(v(1,1,0,0,1,0,0,0,0,1,32'h11111111, 0,1,DB,0));
        tbl.push_back(v(1,1,0,0,1,0,0,0,1,0,0,            2,1,DB,0));
        tbl.push_back(v(1,1,0,0,1,0,0,0,0,1,CF,           0,1,DB,0));
        tbl.push_back(v(1,1,0,0,1,0,1,0,0,0,0,            0,0,DB,CF));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,            0,0,DB,CF));
        // store with three addr_ok wait cycles
        tbl.push_back(v(1,0,0,0,1,0,0,0,0,0,0,            1,1,DB,CF));
        tbl.push_back(v(1,0,0,0,1,0,0,0,0,0,0,            1,1,DB,CF));
        tbl.push_back(v(1,0,0,0,1,0,0,0,0,0,0,            1,1,DB,CF));
        tbl.push_back(v(1,0,0,0,1,0,0,0,1,0,0,            1,1,DB,CF));
        tbl.push_back(v(1,0,0,0,1,0,0,0,0,1,32'h22222222, 0,1,DB,CF));
        tbl.push_back(v(1,0,0,0,1,0,1,0,0,0,0,            0,0,DB,CF));
        // kill1 cancels both slots; kill2 only skips slot 2
        tbl.push_back(v(1,1,1,0,0,0,0,0,0,0,0,  0,0,DB,CF));
        tbl.push_back(v(1,1,0,1,0,0,0,0,1,0,0,  1,1,DB,CF));
        tbl.push_back(v(1,1,0,1,0,0,0,0,0,1,BD, 0,1,DB,CF));
        tbl.push_back(v(1,1,0,1,0,0,1,0,0,0,0,  0,0,BD,CF));
        tbl.push_back(v(0,0,0,0,0,0,0,0,0,0,0,  0,0,BD,CF));

        for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

        // flush while waiting for data_ok: drain the stale response
        run(v(1,0,0,0,0,0,0,0,1,0,0,            1,1,BD,CF));
        run(v(1,0,0,0,0,0,0,1,0,0,0,            0,1,BD,CF));
        run(v(1,0,0,0,0,0,0,0,0,0,0,            0,1,BD,CF));
        run(v(1,0,0,0,0,0,0,0,0,1,32'h12345678, 0,1,BD,CF));
        run(v(1,0,0,0,0,0,0,0,1,0,0,            1,1,BD,CF));
        run(v(1,0,0,0,0,0,0,0,0,1,GD,           0,1,BD,CF));
        run(v(1,0,0,0,0,0,1,0,0,0,0,            0,0,GD,CF));

        // flush while the request waits for addr_ok
        run(v(1,0,0,0,0,0,0,0,0,0,0,            1,1,GD,CF));
        run(v(1,0,0,0,0,0,0,1,0,0,0,            1,1,GD,CF));
        run(v(0,0,0,0,0,0,0,0,1,0,0,            1,1,GD,CF));
        run(v(0,0,0,0,0,0,0,0,0,1,32'h77777777, 0,0,GD,CF));
        run(v(0,0,0,0,0,0,0,0,0,0,0,            0,0,GD,CF));

        // asynchronous reset in the middle of an ADDR wait
        run(v(1,0,0,0,0,0,0,0,0,0,0, 1,1,GD,CF));
        drive(v(1,0,0,0,0,0,0,0,0,0,0, 1,1,GD,CF));
        #1;
        chk("addr_wait_req", {31'b0, data_req}, 32'h1);
        rst = 1'b1;
        #1;
        chk("arst_req",    {31'b0, data_req},  32'h0);
        chk("arst_stall",  {31'b0, mem_stall}, 32'h0);
        chk("arst_addr",   data_addr,          32'h0);
        chk("arst_rdata1", rdata1,             32'h0);
        chk("arst_rdata2", rdata2,             32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        row++;
        run(z);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
